par_clk_switch_ctrl: RTL and testbench
======================================

Name: par_clk_switch_ctrl

Overview:
- Control-side companion to the parallel-clock mux.
- Sequences safe run-time changes of the mux select and power-down controls (clk_sel, clk_pdwn).
- Controls the mux's ready qualifier through a local reset (mux_reset_n) and waits for par_clk_rdy to return.
- Gates the downstream datapath with dp_en, and reverts to the previous clock if the new one never qualifies.

Parameters:
- DEFAULT_SEL, 0, clk_sel value after reset (0 = clk1_in, 1 = clk2_in).
- DEFAULT_PDWN, 0, clk_pdwn value after reset.
- RST_CYCLES, 16, number of cycles mux_reset_n is held low per (re)qualification. Range 1..255.
- DRAIN_CYCLES, 32, number of cycles dp_en is low before a switch is applied. Range 1..255.
- TIMEOUT_CYCLES, 4096, maximum cycles in QUAL waiting for par_clk_rdy. Must exceed 1024 + RST_CYCLES.

Ports:
- clk_reset_n  in  1  async reset, active-low
- par_clk  in  1  clock (mux output)
- sw_req  in  1  single-cycle switch request
- sw_sel  in  1  requested clk_sel, sampled with sw_req
- sw_pdwn  in  1  requested clk_pdwn, sampled with sw_req
- clk1_rdy  in  1  async, die-1 clock ready
- clk2_rdy  in  1  async, die-2 clock ready
- par_clk_rdy  in  1  ready from the mux, par_clk domain
- clk_sel  out  1  mux select
- clk_pdwn  out  1  power-down mode to the mux
- mux_reset_n  out  1  reset to the mux ready qualifier, active-low
- dp_en  out  1  datapath enable
- sw_busy  out  1  switch sequence in progress
- sw_done  out  1  one-cycle pulse when a switch completes
- sw_err  out  1  sticky error flag

Behaviour:
- Reset and clocking:
  - Reset is clk_reset_n, asynchronous, active-low. Clock is par_clk. All flops are async-reset.
  - Reset values: clk_sel=DEFAULT_SEL, clk_pdwn=DEFAULT_PDWN, mux_reset_n=0, dp_en=0, sw_busy=0, sw_done=0, sw_err=0. State is INIT.
- Synchronisers: clk1_rdy and clk2_rdy each pass through a 2-flop synchroniser, giving c1s and c2s.
- Target-ready rule for pending (sel, pdwn):
  - pdwn=1: ready is c2s if sel=1, c1s if sel=0.
  - pdwn=0: ready is c1s & c2s.
- States:
  - INIT:
    - mux_reset_n=0, dp_en=0.
    - Counts RST_CYCLES cycles, then goes to QUAL.
  - QUAL:
    - mux_reset_n=1. Timeout counter starts at 0.
    - par_clk_rdy=1 → RUN. In the same transition, sw_done pulses if sw_busy=1; sw_busy clears.
    - Counter reaching TIMEOUT_CYCLES-1 without par_clk_rdy → FAIL.
  - RUN:
    - dp_en=1 (registered: it rises the cycle after entry).
    - sw_req=1 with (sw_sel,sw_pdwn) equal to current outputs: no-op. sw_done pulses next cycle, sw_err clears, state stays RUN.
    - sw_req=1 with different values: latch pend_sel/pend_pdwn, save prev_sel/prev_pdwn, clear sw_err, set sw_busy → DRAIN.
  - DRAIN: dp_en=0; counts DRAIN_CYCLES cycles → CHECK.
  - CHECK (one cycle):
    - Target ready: clk_sel←pend_sel, clk_pdwn←pend_pdwn, clear reverted flag → INIT.
    - Target not ready: sw_err←1, sw_busy←0, outputs unchanged → RUN.
  - FAIL:
    - dp_en=0, sw_err=1.
    - If sw_busy=1 and reverted flag=0: clk_sel←prev_sel, clk_pdwn←prev_pdwn, set reverted flag → INIT. sw_busy stays 1 and sw_done pulses on requalification; sw_err remains set.
    - Otherwise (startup failure or failed revert): sw_busy←0 and stay in FAIL. An sw_req here latches pending values, sets sw_busy and goes directly to CHECK.
- sw_req rules:
  - sw_req is ignored in INIT, QUAL, DRAIN and CHECK; no queueing.
  - sw_req on the same cycle as a QUAL→RUN transition is ignored.
- Outputs and timing:
  - clk_sel and clk_pdwn change only on CHECK→INIT or the FAIL revert. They are never changed while mux_reset_n=1.
  - Worst-case switch latency: 1 + DRAIN_CYCLES + 1 + RST_CYCLES + mux qualification + 1 cycles.
- Counter width: 8 bits for RST/DRAIN, clog2(TIMEOUT_CYCLES) for the timeout. Counters clear on every state entry.
- Reset asserted mid-sequence: immediate return to reset values and INIT. Pending values are discarded; clk_sel returns to DEFAULT_SEL.

Test Plan:
- Startup: default parameters, mux model asserts par_clk_rdy 1030 cycles after mux_reset_n rises → mux_reset_n low for 16 cycles, dp_en=1 one cycle after par_clk_rdy, sw_done stays 0, sw_err=0.
- Normal switch: c1s=c2s=1, sw_req with sw_sel=1, sw_pdwn=0 → dp_en low for 32 cycles, clk_sel=1 on CHECK exit, mux_reset_n low 16 cycles, sw_done single pulse after par_clk_rdy, sw_busy high throughout.
- Unready target: clk2_rdy=0, sw_req sw_sel=1, sw_pdwn=1 → after 32 drain cycles sw_err=1, clk_sel stays 0, dp_en returns to 1, no sw_done.
- Timeout revert: par_clk_rdy held 0 after a switch to clk2 → FAIL after 4096 QUAL cycles, clk_sel reverts to 0, requalification, sw_done pulse, sw_err remains 1. Next accepted sw_req clears sw_err.
- No-op and ignored requests: sw_req matching current settings → sw_done pulse next cycle, dp_en stays 1. sw_req during DRAIN → ignored, with no second sequence.
- Reset mid-operation: clk_reset_n low during QUAL of a switch → all outputs return to reset values and clk_sel=DEFAULT_SEL. After release, full startup sequence runs again.

Source files
------------

// File: rtl/par_clk_switch_ctrl.sv
// par_clk_switch_ctrl: sequences run-time select/power-down changes of the
// parallel-clock mux, gating the datapath and reverting on failed qualification.
module par_clk_switch_ctrl #(
   parameter logic        DEFAULT_SEL    = 1'b0,
   parameter logic        DEFAULT_PDWN   = 1'b0,
   parameter int unsigned RST_CYCLES     = 16,
   parameter int unsigned DRAIN_CYCLES   = 32,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic clk_reset_n,
   input  logic par_clk,
   input  logic sw_req,
   input  logic sw_sel,
   input  logic sw_pdwn,
   input  logic clk1_rdy,
   input  logic clk2_rdy,
   input  logic par_clk_rdy,
   output logic clk_sel,
   output logic clk_pdwn,
   output logic mux_reset_n,
   output logic dp_en,
   output logic sw_busy,
   output logic sw_done,
   output logic sw_err
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES - 1);
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST =
      TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_INIT,
      S_QUAL,
      S_RUN,
      S_DRAIN,
      S_CHECK,
      S_FAIL
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic c1_meta_q, c1s_q;
   logic c2_meta_q, c2s_q;

   logic sel_q, sel_d;
   logic pdwn_q, pdwn_d;
   logic pend_sel_q, pend_sel_d;
   logic pend_pdwn_q, pend_pdwn_d;
   logic prev_sel_q, prev_sel_d;
   logic prev_pdwn_q, prev_pdwn_d;
   logic reverted_q, reverted_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic err_q, err_d;
   logic mrst_n_q;
   logic dp_en_q;

   logic tgt_rdy;
   logic req_same;

   // Two-flop synchronisers for the die clock-ready flags.
   always_ff @(posedge par_clk or negedge clk_reset_n) begin
      if (!clk_reset_n) begin
         c1_meta_q <= 1'b0;
         c1s_q     <= 1'b0;
         c2_meta_q <= 1'b0;
         c2s_q     <= 1'b0;
      end else begin
         c1_meta_q <= clk1_rdy;
         c1s_q     <= c1_meta_q;
         c2_meta_q <= clk2_rdy;
         c2s_q     <= c2_meta_q;
      end
   end

   // Readiness of the pending target and match against the live setting.
   always_comb begin
      tgt_rdy  = 1'b0;
      req_same = 1'b0;
      if (pend_pdwn_q) begin
         tgt_rdy = pend_sel_q ? c2s_q : c1s_q;
      end else begin
         tgt_rdy = c1s_q & c2s_q;
      end
      req_same = (sw_sel == sel_q) && (sw_pdwn == pdwn_q);
   end

   // Sequencer next-state and control-register updates.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      sel_d       = sel_q;
      pdwn_d      = pdwn_q;
      pend_sel_d  = pend_sel_q;
      pend_pdwn_d = pend_pdwn_q;
      prev_sel_d  = prev_sel_q;
      prev_pdwn_d = prev_pdwn_q;
      reverted_d  = reverted_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;

      unique case (state_q)
         S_INIT: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == RST_LAST) begin
               state_d = S_QUAL;
            end
         end
         S_QUAL: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (par_clk_rdy) begin
               state_d = S_RUN;
               done_d  = busy_q;
               busy_d  = 1'b0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_FAIL;
               err_d   = 1'b1;
            end
         end
         S_RUN: begin
            if (sw_req) begin
               err_d = 1'b0;
               if (req_same) begin
                  done_d = 1'b1;
               end else begin
                  pend_sel_d  = sw_sel;
                  pend_pdwn_d = sw_pdwn;
                  prev_sel_d  = sel_q;
                  prev_pdwn_d = pdwn_q;
                  busy_d      = 1'b1;
                  state_d     = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == DRAIN_LAST) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (tgt_rdy) begin
               sel_d      = pend_sel_q;
               pdwn_d     = pend_pdwn_q;
               reverted_d = 1'b0;
               state_d    = S_INIT;
            end else begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_RUN;
            end
         end
         S_FAIL: begin
            err_d = 1'b1;
            if (busy_q && !reverted_q) begin
               sel_d      = prev_sel_q;
               pdwn_d     = prev_pdwn_q;
               reverted_d = 1'b1;
               state_d    = S_INIT;
            end else if (sw_req) begin
               pend_sel_d  = sw_sel;
               pend_pdwn_d = sw_pdwn;
               prev_sel_d  = sel_q;
               prev_pdwn_d = pdwn_q;
               busy_d      = 1'b1;
               state_d     = S_CHECK;
            end else begin
               busy_d = 1'b0;
            end
         end
         default: begin
            state_d = S_INIT;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
         tmo_d = '0;
      end
   end

   // State, counters and control registers.
   always_ff @(posedge par_clk or negedge clk_reset_n) begin
      if (!clk_reset_n) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         tmo_q       <= '0;
         sel_q       <= DEFAULT_SEL;
         pdwn_q      <= DEFAULT_PDWN;
         pend_sel_q  <= DEFAULT_SEL;
         pend_pdwn_q <= DEFAULT_PDWN;
         prev_sel_q  <= DEFAULT_SEL;
         prev_pdwn_q <= DEFAULT_PDWN;
         reverted_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         sel_q       <= sel_d;
         pdwn_q      <= pdwn_d;
         pend_sel_q  <= pend_sel_d;
         pend_pdwn_q <= pend_pdwn_d;
         prev_sel_q  <= prev_sel_d;
         prev_pdwn_q <= prev_pdwn_d;
         reverted_q  <= reverted_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Mux reset is held only in INIT; datapath enabled only in RUN.
   always_ff @(posedge par_clk or negedge clk_reset_n) begin
      if (!clk_reset_n) begin
         mrst_n_q <= 1'b0;
         dp_en_q  <= 1'b0;
      end else begin
         mrst_n_q <= (state_d != S_INIT);
         dp_en_q  <= (state_d == S_RUN);
      end
   end

   assign clk_sel     = sel_q;
   assign clk_pdwn    = pdwn_q;
   assign mux_reset_n = mrst_n_q;
   assign dp_en       = dp_en_q;
   assign sw_busy     = busy_q;
   assign sw_done     = done_q;
   assign sw_err      = err_q;

endmodule

// File: tb/tb_par_clk_switch_ctrl.sv
// tb_par_clk_switch_ctrl: scoreboard bench with a mux model and a
// transaction-level reference model of switch outcomes.
module tb_par_clk_switch_ctrl;

   localparam int RST_C   = 16;
   localparam int DRAIN_C = 32;
   localparam int TMO_C   = 4096;

   logic clk_reset_n;
   logic par_clk;
   logic sw_req, sw_sel, sw_pdwn;
   logic clk1_rdy, clk2_rdy, par_clk_rdy;
   logic clk_sel, clk_pdwn, mux_reset_n;
   logic dp_en, sw_busy, sw_done, sw_err;

   typedef struct packed {
      logic done;
      logic err;
      logic sel;
      logic pdwn;
   } ev_t;

   ev_t  exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic mux_ok [2];
   int   qual_dly;
   int   qcnt;
   logic m_sel, m_pdwn;
   logic mon_pb;
   int   low_run;
   logic prev_sel;

   par_clk_switch_ctrl #(
      .DEFAULT_SEL(1'b0),
      .DEFAULT_PDWN(1'b0),
      .RST_CYCLES(RST_C),
      .DRAIN_CYCLES(DRAIN_C),
      .TIMEOUT_CYCLES(TMO_C)
   ) dut (
      .clk_reset_n(clk_reset_n),
      .par_clk(par_clk),
      .sw_req(sw_req),
      .sw_sel(sw_sel),
      .sw_pdwn(sw_pdwn),
      .clk1_rdy(clk1_rdy),
      .clk2_rdy(clk2_rdy),
      .par_clk_rdy(par_clk_rdy),
      .clk_sel(clk_sel),
      .clk_pdwn(clk_pdwn),
      .mux_reset_n(mux_reset_n),
      .dp_en(dp_en),
      .sw_busy(sw_busy),
      .sw_done(sw_done),
      .sw_err(sw_err)
   );

   initial par_clk = 1'b0;
   always #5 par_clk = ~par_clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Mux model: qualifies qual_dly cycles after its reset releases,
   // but only if the selected clock is healthy.
   initial begin
      par_clk_rdy = 1'b0;
      qcnt = 0;
      forever begin
         @(posedge par_clk);
         #1;
         if (!mux_reset_n) begin
            par_clk_rdy = 1'b0;
            qcnt = 0;
         end else if (!par_clk_rdy && mux_ok[clk_sel]) begin
            qcnt++;
            if (qcnt >= qual_dly) par_clk_rdy = 1'b1;
         end
      end
   end

   // Scoreboard monitor: every done pulse or busy fall is one outcome.
   initial begin
      ev_t got, e;
      mon_pb = 1'b0;
      forever begin
         @(negedge par_clk);
         if (!clk_reset_n) begin
            mon_pb = 1'b0;
         end else begin
            if (sw_done || (mon_pb && !sw_busy)) begin
               got = {sw_done, sw_err, clk_sel, clk_pdwn};
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL sw_event: got %b expected none", got);
               end else begin
                  e = exp_q.pop_front();
                  if (got != e) begin
                     n_bad++;
                     $display("FAIL sw_event: got %b expected %b", got, e);
                  end
               end
            end
            mon_pb = sw_busy;
         end
      end
   end

   // Protocol monitors: mux reset pulse length, select stability,
   // and datapath enable never raised mid-sequence.
   initial begin
      low_run = 0;
      prev_sel = 1'b0;
      forever begin
         @(negedge par_clk);
         if (!clk_reset_n) begin
            low_run = 0;
         end else begin
            if (!mux_reset_n) begin
               low_run++;
            end else if (low_run != 0) begin
               chk("mux_rst_low_len", low_run, RST_C);
               low_run = 0;
            end
            if (clk_sel != prev_sel) begin
               chk("sel_change_mux_rst", mux_reset_n, 0);
            end
         end
         prev_sel = clk_sel;
      end
   end

   initial begin
      logic pd;
      pd = 1'b0;
      forever begin
         @(negedge par_clk);
         if (clk_reset_n && dp_en && !pd) begin
            chk("dp_en_rise_busy", sw_busy, 0);
         end
         pd = dp_en;
      end
   end

   task automatic model_req(input logic s, input logic p);
      ev_t  e;
      logic rdy;
      rdy = p ? (s ? clk2_rdy : clk1_rdy) : (clk1_rdy & clk2_rdy);
      if (s == m_sel && p == m_pdwn) begin
         e = {1'b1, 1'b0, m_sel, m_pdwn};
      end else if (!rdy) begin
         e = {1'b0, 1'b1, m_sel, m_pdwn};
      end else if (mux_ok[s]) begin
         e = {1'b1, 1'b0, s, p};
         m_sel = s;
         m_pdwn = p;
      end else begin
         e = {1'b1, 1'b1, m_sel, m_pdwn};
      end
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic s, input logic p);
      sw_sel = s;
      sw_pdwn = p;
      sw_req = 1'b1;
      @(negedge par_clk);
      sw_req = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (!(dp_en && !sw_busy) && n < 20000) begin
         @(negedge par_clk);
         n++;
      end
      if (!(dp_en && !sw_busy)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_idle: got dp_en=%0b busy=%0b after %0d cycles",
                  nm, dp_en, sw_busy, n);
      end
   endtask

   task automatic reset_checks(input string nm);
      chk({nm, "_clk_sel"}, clk_sel, 0);
      chk({nm, "_clk_pdwn"}, clk_pdwn, 0);
      chk({nm, "_mux_reset_n"}, mux_reset_n, 0);
      chk({nm, "_dp_en"}, dp_en, 0);
      chk({nm, "_sw_busy"}, sw_busy, 0);
      chk({nm, "_sw_done"}, sw_done, 0);
      chk({nm, "_sw_err"}, sw_err, 0);
   endtask

   task automatic startup_check(input string nm);
      int n;
      n = 0;
      @(negedge par_clk);
      while (!par_clk_rdy && n < 3000) begin
         @(negedge par_clk);
         n++;
      end
      chk({nm, "_mux_qualified"}, par_clk_rdy, 1);
      n = 0;
      while (!dp_en && n < 10) begin
         @(negedge par_clk);
         n++;
      end
      chk({nm, "_dp_en_latency"}, n, 1);
      chk({nm, "_sw_err"}, sw_err, 0);
      chk({nm, "_sw_done"}, sw_done, 0);
      wait_idle(nm);
   endtask

   initial begin
      int   n;
      logic s, p;
      sw_req = 1'b0;
      sw_sel = 1'b0;
      sw_pdwn = 1'b0;
      clk1_rdy = 1'b1;
      clk2_rdy = 1'b1;
      mux_ok[0] = 1'b1;
      mux_ok[1] = 1'b1;
      qual_dly = 1030;
      m_sel = 1'b0;
      m_pdwn = 1'b0;
      clk_reset_n = 1'b0;

      repeat (3) @(negedge par_clk);
      reset_checks("rst");
      @(posedge par_clk);
      #4;
      clk_reset_n = 1'b1;
      startup_check("startup");

      // Normal switch to clk2, both dies ready.
      qual_dly = 40;
      model_req(1'b1, 1'b0);
      issue(1'b1, 1'b0);
      n = 1;
      while (mux_reset_n && n < 200) begin
         @(negedge par_clk);
         n++;
      end
      chk("req_to_mux_rst", n, DRAIN_C + 2);
      chk("sel_at_check_exit", clk_sel, 1);
      chk("busy_in_init", sw_busy, 1);
      wait_idle("switch1");

      // Switch back; a request during drain is ignored.
      model_req(1'b0, 1'b0);
      issue(1'b0, 1'b0);
      repeat (5) @(negedge par_clk);
      chk("busy_in_drain", sw_busy, 1);
      issue(1'b1, 1'b1);
      wait_idle("switch2");

      // Unready target: clk2 not ready.
      clk2_rdy = 1'b0;
      repeat (4) @(negedge par_clk);
      model_req(1'b1, 1'b1);
      issue(1'b1, 1'b1);
      n = 0;
      while (!dp_en && n < 200) begin
         n++;
         @(negedge par_clk);
      end
      chk("unready_dp_en_low", n, DRAIN_C + 1);
      chk("unready_clk_sel", clk_sel, 0);
      chk("unready_sw_err", sw_err, 1);
      clk2_rdy = 1'b1;
      repeat (4) @(negedge par_clk);

      // No-op request clears the error and pulses done next cycle.
      model_req(1'b0, 1'b0);
      issue(1'b0, 1'b0);
      chk("noop_done", sw_done, 1);
      chk("noop_dp_en", dp_en, 1);
      @(negedge par_clk);

      // Timeout and revert: clk2 never qualifies.
      mux_ok[1] = 1'b0;
      model_req(1'b1, 1'b0);
      issue(1'b1, 1'b0);
      n = 0;
      while (mux_reset_n && n < 100) begin
         @(negedge par_clk);
         n++;
      end
      n = 0;
      while (!mux_reset_n && n < 100) begin
         @(negedge par_clk);
         n++;
      end
      n = 0;
      while (mux_reset_n && n < 5000) begin
         n++;
         @(negedge par_clk);
      end
      chk("qual_timeout_len", n, TMO_C + 1);
      chk("revert_clk_sel", clk_sel, 0);
      chk("revert_sw_err", sw_err, 1);
      chk("revert_sw_busy", sw_busy, 1);
      chk("revert_dp_en", dp_en, 0);
      wait_idle("revert");
      chk("revert_err_kept", sw_err, 1);
      mux_ok[1] = 1'b1;

      // Randomised requests against the outcome model.
      for (int i = 0; i < 25; i++) begin
         qual_dly = $urandom_range(300, 5);
         clk1_rdy = ($urandom % 4) != 0;
         clk2_rdy = ($urandom % 4) != 0;
         mux_ok[0] = ($urandom % 5) != 0;
         mux_ok[1] = ($urandom % 5) != 0;
         mux_ok[m_sel] = 1'b1;
         repeat (4) @(negedge par_clk);
         if (($urandom % 5) == 0) begin
            s = m_sel;
            p = m_pdwn;
         end else begin
            s = 1'($urandom);
            p = 1'($urandom);
         end
         model_req(s, p);
         issue(s, p);
         if (($urandom % 2) == 0) begin
            repeat ($urandom_range(40, 1)) @(negedge par_clk);
            if (sw_busy) issue(1'($urandom), 1'($urandom));
         end
         wait_idle("rand");
      end

      // Reset in the middle of a switch's qualification.
      clk1_rdy = 1'b1;
      clk2_rdy = 1'b1;
      mux_ok[0] = 1'b1;
      mux_ok[1] = 1'b1;
      qual_dly = 1030;
      repeat (4) @(negedge par_clk);
      issue(~m_sel, 1'b0);
      n = 0;
      while (mux_reset_n && n < 100) begin
         @(negedge par_clk);
         n++;
      end
      n = 0;
      while (!mux_reset_n && n < 100) begin
         @(negedge par_clk);
         n++;
      end
      repeat (10) @(negedge par_clk);
      clk_reset_n = 1'b0;
      #1;
      reset_checks("midrst");
      m_sel = 1'b0;
      m_pdwn = 1'b0;
      repeat (3) @(negedge par_clk);
      @(posedge par_clk);
      #4;
      clk_reset_n = 1'b1;
      startup_check("restart");

      qual_dly = 20;
      model_req(1'b1, 1'b0);
      issue(1'b1, 1'b0);
      wait_idle("post_reset");
      repeat (4) @(negedge par_clk);

      chk("exp_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
